procyon_tag_freelist: RTL and testbench
=======================================

# procyon_tag_freelist

Circular free-list that hands out binary tags (ROB, LSQ or MSHR indices) one per cycle and reclaims them when the owning entry retires. It sits directly upstream of the binary-to-onehot converter: `o_alloc_tag` feeds `procyon_binary2onehot` to produce the write-enable vector for the tagged structure. Tags are returned in any order. A flush restores the list to the full, in-order reset state.

## Interface
Parameters:
- `OPTN_NUM_TAGS`, default 8: number of tags. Must be a power of two and ≥ 2.
- `TAG_WIDTH`, default `$clog2(OPTN_NUM_TAGS)`: width of one tag.
- `COUNT_WIDTH`, default `$clog2(OPTN_NUM_TAGS+1)`: width of the free count.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `n_rst`  in  1  asynchronous, active-low reset.
- `i_flush`  in  1  restore the list to the reset state.
- `i_alloc_en`  in  1  consumer takes the tag on `o_alloc_tag` this cycle.
- `o_alloc_valid`  out  1  a tag is available.
- `o_alloc_tag`  out  `TAG_WIDTH`  tag at the head of the list.
- `i_free_en`  in  1  return a tag.
- `i_free_tag`  in  `TAG_WIDTH`  tag being returned.
- `o_free_count`  out  `COUNT_WIDTH`  number of tags currently free.
- `o_error`  out  1  sticky illegal-free flag. Only driven when checking is compiled in (see Configuration).

## Operation
- Storage: `OPTN_NUM_TAGS` × `TAG_WIDTH` entry array, plus head and tail pointers of `TAG_WIDTH+1` bits each. The MSB of each pointer is the wrap bit.
- Empty: pointers are exactly equal. Full: pointers differ only in the MSB.
- `o_free_count` = tail − head, computed modulo 2^(`TAG_WIDTH`+1).
- Reset (`n_rst` low):
  - entry[i] = i for every i.
  - head = 0.
  - tail = `OPTN_NUM_TAGS` (wrap bit set, index 0), so the list is full.
  - Outputs: `o_alloc_valid`=1, `o_alloc_tag`=0, `o_free_count`=`OPTN_NUM_TAGS`, `o_error`=0.
- Allocation:
  - `o_alloc_valid` = (count ≠ 0).
  - `o_alloc_tag` = entry[head index], combinational from registered state.
  - Accepted when `i_alloc_en` && `o_alloc_valid`; head increments by 1.
  - `i_alloc_en` while empty is ignored.
- Free:
  - Writes `i_free_tag` into entry[tail index]; tail increments by 1.
  - A free while full is illegal. It is dropped, and the pointers and array are left unchanged.
- Simultaneous alloc and free:
  - Both take effect; count is unchanged.
  - When empty, there is no bypass: the alloc is not accepted and the free is stored. The tag becomes visible the next cycle.
- Flush:
  - `i_flush`=1 loads the reset state (array, pointers and count) at the next edge.
  - It overrides any alloc or free presented in the same cycle.
  - `o_error` is not cleared by flush.

## Timing
- Alloc latency: 0 cycles. A tag is valid in the same cycle it is offered, and the head advances at the edge.
- Free-to-reuse latency: 1 cycle minimum (when the list was empty).
- `o_free_count` reflects an accepted alloc or free one cycle after the edge at which it is taken.
- At most one alloc and one free are taken per cycle.
- Asynchronous reset takes effect immediately, including mid-operation. Outputs reach their reset values without waiting for a clock edge.

## Configuration
- Macro: `PROCYON_FREELIST_DOUBLE_FREE_CHECK_EN`.
- Defined:
  - Maintain an `OPTN_NUM_TAGS`-bit busy vector. A bit is set on an accepted alloc and cleared on an accepted free; the vector is reset and flushed to all zeros.
  - A free is illegal if the tag's busy bit is 0, or if the list is full. An illegal free is dropped, and `o_error` sets at the next edge and stays set until `n_rst`.
  - Alloc and free of the same tag in the same cycle: the alloc sets the bit, and the free is checked against the pre-edge value.
- Undefined: no busy vector exists and `o_error` is tied to 0. Frees are pushed unconditionally, except that a free while full is still dropped.

## Test plan
- Reset, then alloc every cycle with N=8 → tags 0,1,…,7 are issued in order. `o_alloc_valid` drops after 8 allocs and `o_free_count` reads 0.
- Empty list, free tag 5 alone → `o_alloc_valid`=1 and `o_alloc_tag`=5 on the next cycle. Free tag 5 with `i_alloc_en`=1 in the same empty cycle → no alloc is taken that cycle.
- Steady state: alloc and free in the same cycle for 20 cycles → count stays constant and the tags returned appear in free order after wrap-around of both pointers.
- After 3 allocs (count=5), assert `i_flush` together with `i_alloc_en` and `i_free_en` → next cycle count=8, `o_alloc_tag`=0, and the stale free is not recorded.
- With the check macro: alloc tag 0, free 0, free 0 again → the second free is dropped, count is unchanged, and `o_error`=1 and stays set after a flush. Without the macro: `o_error` stays 0.
- Assert `n_rst` low for one cycle mid-stream with count=2 → outputs return to the reset values immediately and count reads 8.

Source files
------------

// File: rtl/procyon_tag_freelist.sv
// procyon_tag_freelist
//
// Circular free-list of binary tags (ROB/LSQ/MSHR indices). One tag is handed
// out per cycle from the head. Returned tags are appended at the tail in any
// order. A flush restores the full, in-order reset contents.
//
// Ports:
//   clk           clock, rising edge
//   n_rst         asynchronous active-low reset
//   i_flush       reload reset state at the next edge (overrides alloc/free)
//   i_alloc_en    consumer takes o_alloc_tag this cycle
//   o_alloc_valid a tag is available (free count != 0)
//   o_alloc_tag   tag at the head of the list
//   i_free_en     return i_free_tag to the list
//   i_free_tag    tag being returned
//   o_free_count  number of free tags (tail - head)
//   o_error       sticky illegal-free flag (double-free check builds only)
//
// Optional feature macro: PROCYON_FREELIST_DOUBLE_FREE_CHECK_EN
//   When defined, a busy vector tracks allocated tags. A free of a tag that is
//   not busy is dropped and sets o_error. When undefined, o_error is tied to 0.
//   In both builds a free while the list is full is dropped.

module procyon_tag_freelist #(
  parameter int OPTN_NUM_TAGS = 8,
  parameter int TAG_WIDTH     = $clog2(OPTN_NUM_TAGS),
  parameter int COUNT_WIDTH   = $clog2(OPTN_NUM_TAGS + 1)
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   i_flush,
  input  logic                   i_alloc_en,
  output logic                   o_alloc_valid,
  output logic [TAG_WIDTH-1:0]   o_alloc_tag,
  input  logic                   i_free_en,
  input  logic [TAG_WIDTH-1:0]   i_free_tag,
  output logic [COUNT_WIDTH-1:0] o_free_count,
  output logic                   o_error
);

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  localparam int PTR_WIDTH = TAG_WIDTH + 1;

  logic [TAG_WIDTH-1:0] entries_q [OPTN_NUM_TAGS];
  logic [TAG_WIDTH-1:0] entries_d [OPTN_NUM_TAGS];
  logic [PTR_WIDTH-1:0] head_q, head_d;
  logic [PTR_WIDTH-1:0] tail_q, tail_d;
  logic [PTR_WIDTH-1:0] count;
  logic                 empty;
  logic                 full;
  logic                 alloc_accept;
  logic                 free_legal;
  logic                 free_accept;

  assign count = tail_q - head_q;
  assign empty = (head_q == tail_q);
  assign full  = (head_q[TAG_WIDTH] != tail_q[TAG_WIDTH]) &&
                 (head_q[TAG_WIDTH-1:0] == tail_q[TAG_WIDTH-1:0]);

  // No bypass: a tag freed into an empty list is only visible next cycle.
  assign o_alloc_valid = !empty;
  assign o_alloc_tag   = entries_q[head_q[TAG_WIDTH-1:0]];
  assign o_free_count  = COUNT_WIDTH'(count);

  assign alloc_accept = i_alloc_en && !empty;
  assign free_accept  = i_free_en && free_legal && !i_flush;

`ifdef PROCYON_FREELIST_DOUBLE_FREE_CHECK_EN
  logic [OPTN_NUM_TAGS-1:0] busy_q, busy_d;
  logic                     error_q, error_d;

  // The free is judged against the pre-edge busy bit, so a same-cycle alloc
  // of the same tag cannot legitimise it.
  assign free_legal = !full && busy_q[i_free_tag];
  assign o_error    = error_q;

  always_comb begin
    busy_d  = busy_q;
    error_d = error_q;
    if (i_flush) begin
      busy_d = '0;
    end else begin
      if (i_free_en && !free_legal) error_d = 1'b1;
      if (free_accept)  busy_d[i_free_tag] = 1'b0;
      // Alloc applied last: on a same-tag alloc+free the bit ends up set.
      if (alloc_accept) busy_d[o_alloc_tag] = 1'b1;
    end
  end

  // Error is sticky across flush; only n_rst clears it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy_q  <= '0;
      error_q <= 1'b0;
    end else begin
      busy_q  <= busy_d;
      error_q <= error_d;
    end
  end
`else
  assign free_legal = !full;
  assign o_error    = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (i_flush) begin
      for (int i = 0; i < OPTN_NUM_TAGS; i++) entries_d[i] = TAG_WIDTH'(i);
      head_d = '0;
      tail_d = PTR_WIDTH'(OPTN_NUM_TAGS);
    end else begin
      if (alloc_accept) head_d = head_q + PTR_WIDTH'(1);
      if (free_accept) begin
        entries_d[tail_q[TAG_WIDTH-1:0]] = i_free_tag;
        tail_d = tail_q + PTR_WIDTH'(1);
      end
    end
  end

  // NOTE: the tag array is reset like any other flop because its contents are
  // architecturally defined at reset (entry[i] = i), not merely don't-care.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < OPTN_NUM_TAGS; i++) entries_q[i] <= TAG_WIDTH'(i);
      head_q <= '0;
      tail_q <= PTR_WIDTH'(OPTN_NUM_TAGS);
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
    end
  end

endmodule

// File: tb/tb_procyon_tag_freelist.sv
// Testbench for procyon_tag_freelist (N = 8). The driver applies directed
// vectors and pushes the hand-computed outputs expected during that cycle into
// a scoreboard queue; an independent monitor pops and compares on each falling
// edge. Expectations that depend on PROCYON_FREELIST_DOUBLE_FREE_CHECK_EN are
// selected through the CHK constant.

module tb_procyon_tag_freelist;

`ifdef PROCYON_FREELIST_DOUBLE_FREE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    string    name;
    bit       valid;
    int       tag;
    int       count;
    bit       err;
  } exp_t;

  logic       clk;
  logic       n_rst;
  logic       i_flush;
  logic       i_alloc_en;
  logic       o_alloc_valid;
  logic [2:0] o_alloc_tag;
  logic       i_free_en;
  logic [2:0] i_free_tag;
  logic [3:0] o_free_count;
  logic       o_error;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  procyon_tag_freelist #(.OPTN_NUM_TAGS(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_flush      (i_flush),
    .i_alloc_en   (i_alloc_en),
    .o_alloc_valid(o_alloc_valid),
    .o_alloc_tag  (o_alloc_tag),
    .i_free_en    (i_free_en),
    .i_free_tag   (i_free_tag),
    .o_free_count (o_free_count),
    .o_error      (o_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input string field, input int actual, input int expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("FAIL %s.%s: got %0d expected %0d", name, field, actual, expected);
    end
  endtask

  // Monitor: compares the DUT outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, "valid", int'(o_alloc_valid), int'(e.valid));
      check(e.name, "count", int'(o_free_count), e.count);
      check(e.name, "error", int'(o_error), int'(e.err));
      if (e.valid) check(e.name, "tag", int'(o_alloc_tag), e.tag);
    end
  end

  task automatic expect_now(input string name, input bit ev, input int et, input int ec, input bit ee);
    exp_t e;
    e.name = name; e.valid = ev; e.tag = et; e.count = ec; e.err = ee;
    sb.push_back(e);
  endtask

  // One cycle: drive inputs, record expected outputs for this cycle, advance.
  task automatic step(input string name, input bit al, input bit fr, input int ft, input bit fl,
                      input bit ev, input int et, input int ec, input bit ee);
    i_alloc_en = al;
    i_free_en  = fr;
    i_free_tag = 3'(ft);
    i_flush    = fl;
    expect_now(name, ev, et, ec, ee);
    @(posedge clk);
    #1;
  endtask

  // Tags expected at the head during 20 cycles of simultaneous alloc+free,
  // starting from head=3, tail=8 with the initial order 2,0,1 of returns.
  int a_tab [20] = '{3, 4, 5, 6, 7, 2, 0, 1, 3, 4, 5, 6, 7, 2, 0, 1, 3, 4, 5, 6};
  int f_init [3] = '{2, 0, 1};

  initial begin
    n_rst = 1'b0; i_flush = 1'b0; i_alloc_en = 1'b0; i_free_en = 1'b0; i_free_tag = '0;
    expect_now("reset", 1'b1, 0, 8, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    n_rst = 1'b1;

    // Drain the full list in order.
    for (int k = 0; k < 8; k++) step("alloc_seq", 1, 0, 0, 0, 1, k, 8 - k, 0);
    step("alloc_empty", 1, 0, 0, 0, 0, 0, 0, 0);

    // Free into an empty list: no bypass, visible next cycle.
    step("free_alloc_empty", 1, 1, 5, 0, 0, 0, 0, 0);
    step("free_visible",     1, 0, 0, 0, 1, 5, 1, 0);
    step("free_alone",       0, 1, 5, 0, 0, 0, 0, 0);
    step("free_alone_vis",   0, 0, 0, 0, 1, 5, 1, 0);
    step("flush_idle",       0, 0, 0, 1, 1, 5, 1, 0);

    // Three allocs, then steady alloc+free with wrap of both pointers.
    for (int k = 0; k < 3; k++) step("post_flush", 1, 0, 0, 0, 1, k, 8 - k, 0);
    for (int s = 0; s < 20; s++)
      step("steady", 1, 1, (s < 3) ? f_init[s] : a_tab[s - 3], 0, 1, a_tab[s], 5, 0);

    // Flush overriding a same-cycle alloc and free.
    step("flush_idle2", 0, 0, 0, 1, 1, 7, 5, 0);
    for (int k = 0; k < 3; k++) step("pre_override", 1, 0, 0, 0, 1, k, 8 - k, 0);
    step("flush_override", 1, 1, 1, 1, 1, 3, 5, 0);

    // Double free of tag 0.
    step("after_flush", 1, 0, 0, 0, 1, 0, 8, 0);
    step("df_alloc",    1, 0, 0, 0, 1, 1, 7, 0);
    step("df_free1",    0, 1, 0, 0, 1, 2, 6, 0);
    step("df_free2",    0, 1, 0, 0, 1, 2, 7, 0);
    step("df_after",    0, 0, 0, 0, 1, 2, CHK ? 7 : 8, CHK);
    step("df_flush",    0, 0, 0, 1, 1, 2, CHK ? 7 : 8, CHK);

    // Free while full is dropped in every build.
    step("full_free",   0, 1, 3, 0, 1, 0, 8, CHK);
    step("full_drop",   0, 0, 0, 0, 1, 0, 8, CHK);

    // Bring count to 2, then async reset mid-cycle.
    for (int k = 0; k < 6; k++) step("pre_rst", 1, 0, 0, 0, 1, k, 8 - k, CHK);
    step("cnt2", 0, 0, 0, 0, 1, 6, 2, CHK);
    n_rst = 1'b0;
    expect_now("async_rst", 1'b1, 0, 8, 1'b0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    step("post_rst",  1, 0, 0, 0, 1, 0, 8, 0);
    step("post_rst2", 0, 0, 0, 0, 1, 1, 7, 0);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    #1;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
